// File: rtl/grid_display_scanner.sv
// grid_display_scanner
//
// Consumes 64-bit Game of Life generation words (8x8 grid, cell (r,c) is
// bit 8r+c). An accepted word waits in a pending buffer and is moved into the
// display buffer only at a frame boundary, so the matrix never shows half of
// one generation and half of the next. The displayed grid is scanned one row
// at a time. Each row lasts DWELL cycles, and the first of those cycles is
// blanked so that no ghosting appears between rows.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   grid_in     generation word
//   grid_valid  grid_in is valid this cycle
//   grid_ready  pending buffer empty; word taken on grid_valid && grid_ready
//   row_sel     one-hot row drive, 0 while blanking
//   col_data    column data of the driven row, 0 while blanking
//   frame_done  one-cycle pulse following each frame boundary
//   gen_count   generations swapped into display, saturating
//   still_life  last swapped grid equals the grid it replaced
//   extinct     last swapped grid is empty
//
// DWELL: cycles per row including the blanking cycle (2..65535).

module grid_display_scanner #(
    parameter int unsigned DWELL = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid_in,
    input  logic        grid_valid,
    output logic        grid_ready,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done,
    output logic [15:0] gen_count,
    output logic        still_life,
    output logic        extinct
);

    localparam logic [15:0] CNT_LAST = 16'(DWELL - 1);

    logic [63:0] r_display;
    logic [63:0] r_pending;
    logic        r_pending_valid;
    logic [2:0]  r_row;
    logic [15:0] r_cnt;
    logic [15:0] r_gen_count;
    logic        r_still_life;
    logic        r_extinct;
    logic        r_frame_done;

    logic        w_cnt_wrap;
    logic        w_boundary;
    logic        w_swap;
    logic        w_accept;

    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_boundary = w_cnt_wrap && (r_row == 3'd7);
    assign w_swap     = w_boundary && r_pending_valid;
    // Acceptance depends only on registered state, so a word offered on the
    // swap edge is refused; grid_ready only rises on the following cycle.
    assign w_accept   = grid_valid && !r_pending_valid;

    // Scan position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (w_cnt_wrap) begin
                r_cnt <= '0;
                r_row <= r_row + 3'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Pending/display buffers and generation status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_display       <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_gen_count     <= '0;
            r_still_life    <= 1'b0;
            r_extinct       <= 1'b0;
        end else if (w_swap) begin
            r_display       <= r_pending;
            r_pending_valid <= 1'b0;
            r_gen_count     <= (r_gen_count == 16'hFFFF) ? r_gen_count
                                                         : r_gen_count + 16'd1;
            r_still_life    <= (r_pending == r_display);
            r_extinct       <= (r_pending == 64'd0);
        end else if (w_accept) begin
            r_pending       <= grid_in;
            r_pending_valid <= 1'b1;
        end
    end

    // Row drive; cnt==0 is the blanking slot of every row
    always_comb begin
        row_sel  = '0;
        col_data = '0;
        if (r_cnt != 16'd0) begin
            row_sel  = 8'd1 << r_row;
            col_data = r_display[{r_row, 3'b000} +: 8];
        end
    end

    assign grid_ready = !r_pending_valid;
    assign frame_done = r_frame_done;
    assign gen_count  = r_gen_count;
    assign still_life = r_still_life;
    assign extinct    = r_extinct;

endmodule

// File: doc/grid_display_scanner.md
# grid_display_scanner

Downstream consumer of the Game of Life evolution stage. Captures each 64-bit generation word (8x8 grid) into a pending buffer and swaps it into a display buffer only at frame boundaries to prevent tearing. Scans the displayed grid one row at a time onto an 8x8 LED matrix. Reports generation count, still-life and extinction status for the top-level controller.

## Interface

Parameters:
- DWELL, 1000: clock cycles per row, including one blanking cycle. Legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- grid_in  input  64  generation word; cell (r,c) = grid_in[8r+c].
- grid_valid  input  1  grid_in is valid this cycle.
- grid_ready  output  1  pending buffer empty; a word is accepted on grid_valid && grid_ready.
- row_sel  output  8  one-hot active-high row drive; 0 during blanking.
- col_data  output  8  column data for the driven row; 0 during blanking.
- frame_done  output  1  one-cycle pulse after every frame boundary.
- gen_count  output  16  number of generations displayed; saturates at 16'hFFFF.
- still_life  output  1  last swapped-in grid equals the one it replaced.
- extinct  output  1  last swapped-in grid is all zeros.

## Operation

- State: display[63:0], pending[63:0], pending_valid, row[2:0], cnt[15:0], plus output registers.
- grid_ready = ~pending_valid. This is a decode of registered state only.
- Accept: on grid_valid && grid_ready, set pending <= grid_in and pending_valid <= 1.
- Drop: grid_valid while grid_ready=0 is ignored. It causes no state change and no error flag.
- Scan counter: cnt counts 0..DWELL-1. On wrap, cnt returns to 0 and row increments mod 8.
- Frame boundary: the edge at which row==7 and cnt==DWELL-1. At that edge:
  - frame_done <= 1; it is 0 on all other edges.
  - If pending_valid:
    - display <= pending
    - pending_valid <= 0
    - gen_count <= sat(gen_count+1)
    - still_life <= (pending == display)
    - extinct <= (pending == 0)
  - If not pending_valid: display, gen_count, still_life and extinct hold.
- Drive:
  - cnt==0: row_sel=0 and col_data=0 (blanking).
  - Otherwise: row_sel=1<<row and col_data=display[8*row +: 8].
  - Both are combinational decodes of registered state.
- Simultaneous accept and swap: at the boundary edge with pending_valid=1, grid_valid is ignored because grid_ready=0 that cycle. The word is not captured. grid_ready rises the following cycle.
- Reset, asynchronous at any time:
  - display, pending, pending_valid, row, cnt, gen_count, still_life, extinct and frame_done all go to 0.
  - A pending word is lost. The scan restarts at row 0 with cnt 0.

## Timing

- Frame length is exactly 8*DWELL cycles. The first boundary occurs 8*DWELL edges after reset release.
- Reset values: grid_ready=1, row_sel=0, col_data=0, frame_done=0, gen_count=0, still_life=0, extinct=0.
- Accept latency: a word accepted at edge t is displayed from the first frame boundary after t.
  - It becomes visible on row 0 at cnt==1 of the following frame.
  - Worst case from acceptance to first display: 8*DWELL+1 cycles.
- frame_done is high for exactly one cycle: the cycle with row==0 and cnt==0 that follows a boundary. It is never high after reset until the first boundary.
- Status outputs update on the same edge as the display swap.
- Throughput: at most one generation per frame. Upstream must hold grid_valid or retry until grid_ready=1.

## Test plan

All scenarios use DWELL=4 (32-cycle frame).

- Reset: assert reset low mid-row 5 with pending_valid=1 -> all outputs 0 and grid_ready=1 immediately. After release, row 0 cnt 0; the pending word is never displayed.
- Load: grid_valid with 64'h8000_0000_0000_00FF at cycle 3.
  - grid_ready is 0 from cycle 4 until the boundary.
  - Next frame: row 0 shows col_data=8'hFF, row 7 shows 8'h80, other rows show 8'h00, with row_sel=0 at every cnt==0.
  - gen_count=1 and frame_done pulses at cycle 32.
- Backpressure: two grid_valid pulses in one frame, 64'h1 then 64'h2 -> second ignored. Display shows 64'h1 next frame; gen_count=1.
- Boundary collision: grid_valid 64'hF0 on the boundary edge while pending_valid=1 -> word dropped. grid_ready=1 on the next cycle; gen_count increments once.
- Still life and extinction: load 64'h0000_0000_0018_1800 twice in consecutive frames -> still_life=1, extinct=0, gen_count=2. Then load 64'h0 -> extinct=1, still_life=0, gen_count=3.
- Saturation: force gen_count to 16'hFFFE and swap twice -> 16'hFFFF and holds.
